ex_hilo_unit: RTL and testbench
===============================

# ex_hilo_unit

Multi-cycle HI/LO execution unit inside the EX stage of the 5-stage pipeline, directly upstream of the MEM stage. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO pair, written back from WB. It also supplies forwarded HI/LO values for MFHI/MFLO. It drives the 65-bit `ex_mem_lohi_bus` consumed by MEM and raises `stallreq` while an iterative operation is in flight.

## Interface
- No parameters. Widths are fixed at 32-bit data and a 65-bit HI/LO bus `{we[64], hi[63:32], lo[31:0]}`.
- clk  in  1  clock. Reset rst is synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- stall  in  6  pipeline stall vector. Only stall[2] (EX hold, 1 = Stop) is used.
- op  in  3  operation present in EX: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- rs_data  in  32  operand A / MTHI/MTLO source.
- rt_data  in  32  operand B.
- mem_ex_lohi_bus  in  65  HI/LO result currently in MEM (forwarding).
- wb_ex_lohi_bus  in  65  HI/LO result in WB. Its `we` commits to the internal HI/LO registers.
- hi_rdata  out  32  forwarded HI for MFHI.
- lo_rdata  out  32  forwarded LO for MFLO.
- ex_mem_lohi_bus  out  65  HI/LO write request toward MEM.
- stallreq  out  1  request to hold IF/ID/EX.

## Operation
**Forwarding**
- hi_rdata/lo_rdata source priority: MEM bus if its we=1, else WB bus if its we=1, else internal registers.

**Architectural HI/LO**
- Internal HI/LO registers load from `wb_ex_lohi_bus` on every edge with we=1.

**MTHI / MTLO**
- Combinational, no stall.
- MTHI: bus = {1, rs_data, lo_rdata}.
- MTLO: bus = {1, hi_rdata, rs_data}.

**FSM states: IDLE, BUSY, DONE**
- IDLE
  - op ∈ {MULT, MULTU, DIV, DIVU}: latch absolute operands, sign flags and op kind; counter←0; go to BUSY. stallreq=1 combinationally in this cycle.
  - Otherwise stay in IDLE.
- BUSY
  - One iteration per cycle; stallreq=1.
  - After the 32nd iteration (counter==31), go to DONE.
- DONE
  - stallreq=0; bus = {1, result_hi, result_lo}.
  - Go to IDLE at the first edge with stall[2]==0.
  - While stall[2]==1, hold DONE and the result stable.
- `op` is sampled only in IDLE. Changes to op or operands during BUSY/DONE are ignored.

**Multiply**
- Shift-add over |A|·|B|, 64-bit product.
- MULT negates the product if sign(A)≠sign(B). HI=product[63:32], LO=product[31:0].

**Divide**
- Restoring, one quotient bit per cycle, on magnitudes.
- DIV: quotient negated if sign(A)≠sign(B); remainder takes the sign of A.
- Result: LO=quotient, HI=remainder.
- Divide by zero: LO=0xFFFFFFFF, HI=rs_data (signed and unsigned).
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.

**Idle output**
- bus = 65'b0 whenever no operation produces a write (IDLE with op none/reserved, or BUSY).

## Timing
- Reset values: state=IDLE, counter=0, HI=LO=0, stallreq=0, bus=0.
- Iterative op latency: 1 start cycle + 32 BUSY cycles, all stalled, then 1 DONE cycle carrying the result. The instruction occupies EX for 34 cycles minimum.
- MEM captures `ex_mem_lohi_bus` at the DONE edge where stall[2]==0.
- Back-to-back: a second multi-cycle op arriving in EX right after DONE starts from IDLE on the next cycle. No bubble beyond its own latency.
- rst during BUSY/DONE: abort immediately. The next cycle is IDLE with the reset values above; no partial write is ever emitted.
- WB commit and an EX operation in the same cycle: WB commits; forwarding already reflects it combinationally.

## Configuration
- `HILO_FAST_MUL_EN` defined:
  - MULT/MULTU are single-cycle, combinational signed/unsigned 32×32 multiply.
  - stallreq=0; the result is on the bus in the same cycle, like MTHI.
  - FSM is used only for DIV/DIVU.
- Undefined: MULT/MULTU use the 34-cycle iterative path above.

## Test plan
- DIVU 100/7: stallreq high 33 cycles, then DONE bus = {1, 0x00000002, 0x0000000E}; HI/LO=2/14 after WB.
- DIV −7/2 (0xFFFFFFF9/2): LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 5/0: LO=0xFFFFFFFF, HI=5.
- MULT 0xFFFFFFFF×2: HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands: HI=1, LO=0xFFFFFFFE. Latency is 34 cycles without the macro and 0 stall cycles with it.
- MTHI 0x1234 with MEM bus carrying {1, 0xAAAA, 0xBBBB}: bus = {1, 0x1234, 0xBBBB}. hi_rdata prefers MEM over WB when both have we=1.
- Hold DONE with stall[2]=1 for 3 cycles: result stable, stallreq=0; IDLE one cycle after stall[2] drops.
- Assert rst at BUSY counter=10: next cycle IDLE, stallreq=0, bus=0, HI=LO=0.

Source files
------------

// File: rtl/ex_hilo_unit.sv
// ex_hilo_unit: multi-cycle HI/LO execution unit for the EX stage.
//
// This unit executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and holds the
// architectural HI/LO pair that is committed from WB. It also forwards HI/LO
// values for MFHI/MFLO.
//
// Iterative operations use a three-state FSM (IDLE -> BUSY -> DONE). The
// FSM spends 32 BUSY cycles on shift-add multiply or restoring divide,
// working on operand magnitudes, and fixes the signs up in DONE.
//
// Optional build macro HILO_FAST_MUL_EN: when it is defined, MULT/MULTU use
// a single-cycle combinational multiplier, and the FSM serves only DIV/DIVU.

module ex_hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [64:0] mem_ex_lohi_bus,
    input  logic [64:0] wb_ex_lohi_bus,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata,
    output logic [64:0] ex_mem_lohi_bus,
    output logic        stallreq
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Architectural HI/LO
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    // FSM and iteration datapath
    logic [1:0]  state_r;
    logic [4:0]  counter_r;
    logic [31:0] p_hi_r;      // product high half / running remainder
    logic [31:0] p_lo_r;      // multiplier bits / dividend bits -> quotient
    logic [31:0] b_r;         // |multiplicand| or |divisor|
    logic [31:0] a_orig_r;    // raw rs_data, returned as HI on divide by zero
    logic        is_div_r;
    logic        neg_q_r;     // negate product / quotient
    logic        neg_rem_r;   // negate remainder (signed divide, A negative)
    logic        div_zero_r;

    // Decode and operand conditioning
    logic        op_mul_s;
    logic        op_div_s;
    logic        op_signed_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic        start_s;

    // Iteration step
    logic [32:0] mul_sum_s;
    logic [32:0] div_trial_s;
    logic [32:0] div_diff_s;
    logic        div_ge_s;
    logic [31:0] p_hi_nx_s;
    logic [31:0] p_lo_nx_s;

    // Result fix-up
    logic [63:0] prod_raw_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    // Only stall[2] (the EX hold) is used; the remaining bits are
    // deliberately ignored.
    logic        stall_unused_s;

`ifdef HILO_FAST_MUL_EN
    logic [63:0] fast_prod_s;
    logic        fast_mul_s;
`endif

    assign stall_unused_s = ^{stall[5:3], stall[1:0]};

    assign op_mul_s    = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div_s    = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_signed_s = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg_s     = op_signed_s & rs_data[31];
    assign b_neg_s     = op_signed_s & rt_data[31];
    assign abs_a_s     = a_neg_s ? (32'd0 - rs_data) : rs_data;
    assign abs_b_s     = b_neg_s ? (32'd0 - rt_data) : rt_data;

`ifdef HILO_FAST_MUL_EN
    assign start_s     = (state_r == ST_IDLE) && op_div_s;
    assign fast_mul_s  = (state_r == ST_IDLE) && op_mul_s;
    assign fast_prod_s = (op == OP_MULT)
                       ? 64'($signed({{32{rs_data[31]}}, rs_data}) *
                             $signed({{32{rt_data[31]}}, rt_data}))
                       : ({32'd0, rs_data} * {32'd0, rt_data});
`else
    assign start_s     = (state_r == ST_IDLE) && (op_mul_s || op_div_s);
`endif

    // Forwarded HI/LO: the MEM bus wins over the WB bus, which wins over the
    // registers.
    always_comb begin
        hi_rdata = hi_r;
        lo_rdata = lo_r;
        if (mem_ex_lohi_bus[64]) begin
            hi_rdata = mem_ex_lohi_bus[63:32];
            lo_rdata = mem_ex_lohi_bus[31:0];
        end else if (wb_ex_lohi_bus[64]) begin
            hi_rdata = wb_ex_lohi_bus[63:32];
            lo_rdata = wb_ex_lohi_bus[31:0];
        end else begin
            hi_rdata = hi_r;
            lo_rdata = lo_r;
        end
    end

    assign mul_sum_s   = {1'b0, p_hi_r} + (p_lo_r[0] ? {1'b0, b_r} : 33'd0);
    assign div_trial_s = {p_hi_r, p_lo_r[31]};
    assign div_diff_s  = div_trial_s - {1'b0, b_r};
    assign div_ge_s    = (div_trial_s >= {1'b0, b_r});

    // One shift-add or restoring-divide step
    always_comb begin
        p_hi_nx_s = p_hi_r;
        p_lo_nx_s = p_lo_r;
        if (is_div_r) begin
            if (div_ge_s) begin
                p_hi_nx_s = div_diff_s[31:0];
                p_lo_nx_s = {p_lo_r[30:0], 1'b1};
            end else begin
                p_hi_nx_s = div_trial_s[31:0];
                p_lo_nx_s = {p_lo_r[30:0], 1'b0};
            end
        end else begin
            p_hi_nx_s = mul_sum_s[32:1];
            p_lo_nx_s = {mul_sum_s[0], p_lo_r[31:1]};
        end
    end

    assign prod_raw_s = {p_hi_r, p_lo_r};
    assign prod_s     = neg_q_r ? (64'd0 - prod_raw_s) : prod_raw_s;

    // Sign fix-up and the divide-by-zero convention for the DONE result
    always_comb begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        if (is_div_r) begin
            if (div_zero_r) begin
                res_hi_s = a_orig_r;
                res_lo_s = 32'hFFFF_FFFF;
            end else begin
                res_hi_s = neg_rem_r ? (32'd0 - p_hi_r) : p_hi_r;
                res_lo_s = neg_q_r   ? (32'd0 - p_lo_r) : p_lo_r;
            end
        end else begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end
    end

    // Bus toward MEM and the stall request, decoded from the state and the
    // current op
    always_comb begin
        ex_mem_lohi_bus = 65'd0;
        stallreq        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    stallreq = 1'b1;
`ifdef HILO_FAST_MUL_EN
                end else if (fast_mul_s) begin
                    ex_mem_lohi_bus = {1'b1, fast_prod_s};
`endif
                end else if (op == OP_MTHI) begin
                    ex_mem_lohi_bus = {1'b1, rs_data, lo_rdata};
                end else if (op == OP_MTLO) begin
                    ex_mem_lohi_bus = {1'b1, hi_rdata, rs_data};
                end else begin
                    ex_mem_lohi_bus = 65'd0;
                end
            end
            ST_BUSY: begin
                stallreq = 1'b1;
            end
            ST_DONE: begin
                ex_mem_lohi_bus = {1'b1, res_hi_s, res_lo_s};
            end
            default: begin
                ex_mem_lohi_bus = 65'd0;
                stallreq        = 1'b0;
            end
        endcase
    end

    // The architectural HI/LO registers commit whatever WB presents with
    // we set
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (wb_ex_lohi_bus[64]) begin
            hi_r <= wb_ex_lohi_bus[63:32];
            lo_r <= wb_ex_lohi_bus[31:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Sequence IDLE -> BUSY (32 steps) -> DONE; DONE is held while EX is
    // stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            counter_r  <= 5'd0;
            p_hi_r     <= 32'd0;
            p_lo_r     <= 32'd0;
            b_r        <= 32'd0;
            a_orig_r   <= 32'd0;
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_BUSY;
                        counter_r  <= 5'd0;
                        p_hi_r     <= 32'd0;
                        p_lo_r     <= abs_a_s;
                        b_r        <= abs_b_s;
                        a_orig_r   <= rs_data;
                        is_div_r   <= op_div_s;
                        neg_q_r    <= a_neg_s ^ b_neg_s;
                        neg_rem_r  <= a_neg_s;
                        div_zero_r <= (rt_data == 32'd0);
                    end
                end
                ST_BUSY: begin
                    p_hi_r    <= p_hi_nx_s;
                    p_lo_r    <= p_lo_nx_s;
                    counter_r <= counter_r + 5'd1;
                    if (counter_r == 5'd31) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!stall[2]) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_hilo_unit.sv
// Directed testbench for ex_hilo_unit (default build or HILO_FAST_MUL_EN).
module tb_ex_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [64:0] mem_ex_lohi_bus;
    logic [64:0] wb_ex_lohi_bus;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;
    logic [64:0] ex_mem_lohi_bus;
    logic        stallreq;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef HILO_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif

    ex_hilo_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .op              (op),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .mem_ex_lohi_bus (mem_ex_lohi_bus),
        .wb_ex_lohi_bus  (wb_ex_lohi_bus),
        .hi_rdata        (hi_rdata),
        .lo_rdata        (lo_rdata),
        .ex_mem_lohi_bus (ex_mem_lohi_bus),
        .stallreq        (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op      = o;
        rs_data = a;
        rt_data = b;
        #1;
    endtask

    // Count stalled cycles from the current (start) cycle until stallreq drops
    task automatic wait_done(input string tag, input int exp_n, input logic [64:0] exp_bus);
        int n;
        n = 0;
        while (stallreq === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_lat"}, 65'(n), 65'(exp_n));
        chk({tag, "_bus"}, ex_mem_lohi_bus, exp_bus);
        chk({tag, "_nostall"}, 65'(stallreq), 65'd0);
    endtask

    task automatic idle_next(input string tag);
        op = 3'd0;
        tick();
        chk(tag, ex_mem_lohi_bus, 65'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 6'd0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
        mem_ex_lohi_bus = 65'd0; wb_ex_lohi_bus = 65'd0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        chk("rst_stallreq", 65'(stallreq), 65'd0);
        chk("rst_bus", ex_mem_lohi_bus, 65'd0);
        chk("rst_hi", 65'(hi_rdata), 65'd0);
        chk("rst_lo", 65'(lo_rdata), 65'd0);

        // DIVU 100/7
        issue(3'd4, 32'd100, 32'd7);
        chk("divu_start_stall", 65'(stallreq), 65'd1);
        wait_done("divu", 33, {1'b1, 32'h0000_0002, 32'h0000_000E});
        idle_next("divu_idle");

        // WB commit of the DIVU result
        wb_ex_lohi_bus = {1'b1, 32'h0000_0002, 32'h0000_000E};
        #1;
        chk("fwd_wb_hi", 65'(hi_rdata), 65'h2);
        tick();
        wb_ex_lohi_bus = 65'd0;
        #1;
        chk("arch_hi", 65'(hi_rdata), 65'h2);
        chk("arch_lo", 65'(lo_rdata), 65'hE);

        // DIV -7/2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 33, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        idle_next("div_neg_idle");

        // DIV 5/0, then a DIVU 9/3 arriving straight after DONE
        issue(3'd3, 32'd5, 32'd0);
        wait_done("div_zero", 33, {1'b1, 32'h0000_0005, 32'hFFFF_FFFF});
        op = 3'd4; rs_data = 32'd9; rt_data = 32'd3;
        tick();
        chk("b2b_start", 65'(stallreq), 65'd1);
        wait_done("b2b", 33, {1'b1, 32'h0000_0000, 32'h0000_0003});
        idle_next("b2b_idle");

        // DIV overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 33, {1'b1, 32'h0000_0000, 32'h8000_0000});
        idle_next("div_ovf_idle");

        // MULT / MULTU 0xFFFFFFFF x 2
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done("mult", MUL_LAT, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        idle_next("mult_idle");
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu", MUL_LAT, {1'b1, 32'h0000_0001, 32'hFFFF_FFFE});
        idle_next("multu_idle");

        // MTHI/MTLO with forwarding sources (no clock edge while WB we=1)
        mem_ex_lohi_bus = {1'b1, 32'h0000_AAAA, 32'h0000_BBBB};
        wb_ex_lohi_bus  = {1'b1, 32'h0000_CCCC, 32'h0000_DDDD};
        issue(3'd5, 32'h0000_1234, 32'd0);
        chk("mthi_bus", ex_mem_lohi_bus, {1'b1, 32'h0000_1234, 32'h0000_BBBB});
        chk("fwd_mem_hi", 65'(hi_rdata), 65'hAAAA);
        chk("mthi_nostall", 65'(stallreq), 65'd0);
        mem_ex_lohi_bus = 65'd0;
        issue(3'd6, 32'h0000_5678, 32'd0);
        chk("mtlo_bus", ex_mem_lohi_bus, {1'b1, 32'h0000_CCCC, 32'h0000_5678});
        chk("fwd_wb_lo", 65'(lo_rdata), 65'hDDDD);
        wb_ex_lohi_bus = 65'd0;
        op = 3'd0;
        tick();

        // Hold DONE for 3 cycles with stall[2]=1
        stall = 6'b000100;
        issue(3'd4, 32'd100, 32'd7);
        wait_done("hold", 33, {1'b1, 32'h0000_0002, 32'h0000_000E});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_bus", ex_mem_lohi_bus, {1'b1, 32'h0000_0002, 32'h0000_000E});
            chk("hold_nostall", 65'(stallreq), 65'd0);
        end
        stall = 6'd0;
        op = 3'd0;
        tick();
        chk("hold_release_bus", ex_mem_lohi_bus, 65'd0);
        chk("hold_release_stall", 65'(stallreq), 65'd0);

        // Reset in BUSY at counter 10
        issue(3'd4, 32'd100, 32'd7);
        tick();
        repeat (10) @(posedge clk);
        #2;
        chk("busy_before_rst", 65'(stallreq), 65'd1);
        rst = 1'b1;
        op  = 3'd0;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_stall", 65'(stallreq), 65'd0);
        chk("abort_bus", ex_mem_lohi_bus, 65'd0);
        chk("abort_hi", 65'(hi_rdata), 65'd0);
        chk("abort_lo", 65'(lo_rdata), 65'd0);
        tick();
        chk("abort_idle", 65'(stallreq), 65'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
